// File: rtl/mult_pkg.sv
// Shared types and helpers for the radix-8 Booth sequential multiplier.
//   booth_digit_e : recoded Booth digit, -4..+4
//   ngrp_f()      : number of radix-8 groups needed for a BITS-wide operand
//                   extended by one sign bit, i.e. ceil((BITS+1)/3)
package mult_pkg;

  typedef enum logic [3:0] {
    ZERO,
    P1, P2, P3, P4,
    N1, N2, N3, N4
  } booth_digit_e;

  function automatic int unsigned ngrp_f(input int unsigned bits);
    return (bits + 3) / 3;
  endfunction

endpackage

// File: rtl/booth8_recoder.sv
// Combinational radix-8 Booth recoder.
// Ports:
//   grp_i   : {q[3k+2], q[3k+1], q[3k], q[3k-1]} for group k
//   digit_o : digit value -4*b2 + 2*b1 + b0 + b(-1)
module booth8_recoder
  import mult_pkg::*;
(
  input  logic [3:0]   grp_i,
  output booth_digit_e digit_o
);

  always_comb begin
    digit_o = ZERO;
    case (grp_i)
      4'b0001, 4'b0010: digit_o = P1;
      4'b0011, 4'b0100: digit_o = P2;
      4'b0101, 4'b0110: digit_o = P3;
      4'b0111:          digit_o = P4;
      4'b1000:          digit_o = N4;
      4'b1001, 4'b1010: digit_o = N3;
      4'b1011, 4'b1100: digit_o = N2;
      4'b1101, 4'b1110: digit_o = N1;
      default:          digit_o = ZERO;
    endcase
  end

endmodule

// File: rtl/mult_booth8_seq.sv
// Sequential radix-8 Booth multiplier: one Booth group per clock, NGRP
// cycles per product, valid/ready handshake on both sides.
// Ports:
//   iClk, iRst      : clock, synchronous active-high reset
//   iValid / oReady : operand handshake (iM, iQ, optional iSigned)
//   oValid / iReady : product handshake (oZ = iM*iQ mod 2^(2*BITS))
// Configuration macro: MULT_SIGNED_EN adds the iSigned port; without it
// both operands are unsigned.
module mult_booth8_seq
  import mult_pkg::*;
#(
  parameter int unsigned BITS = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iValid,
  output logic              oReady,
  input  logic [BITS-1:0]   iM,
  input  logic [BITS-1:0]   iQ,
`ifdef MULT_SIGNED_EN
  input  logic              iSigned,
`endif
  output logic              oValid,
  input  logic              iReady,
  output logic [2*BITS-1:0] oZ
);

  localparam int unsigned NGRP = ngrp_f(BITS);
  localparam int unsigned MW   = BITS + 1;      // extended operand
  localparam int unsigned XW   = BITS + 3;      // room for +-4*M
  localparam int unsigned QW   = 3 * NGRP;      // multiplier covering all groups
  localparam int unsigned AW   = 2 * BITS + 3;  // accumulator
  localparam int unsigned CW   = $clog2(NGRP + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] m_q, m_d;
  logic [XW-1:0] m3_q, m3_d;
  logic [QW-1:0] q_q, q_d;
  logic          qprev_q, qprev_d;
  logic [AW-1:0] acc_q, acc_d;

  logic          sgn;
  logic          accept;
  logic [MW-1:0] m_ext, q_ext;
  logic [XW-1:0] m_cap_w, m_w, mag, sel;
  logic [AW-1:0] pp;
  int unsigned   shamt;
  booth_digit_e  digit;

`ifdef MULT_SIGNED_EN
  assign sgn = iSigned;
`else
  assign sgn = 1'b0;
`endif

  assign m_ext   = {sgn & iM[BITS-1], iM};
  assign q_ext   = {sgn & iQ[BITS-1], iQ};
  assign m_cap_w = XW'($signed(m_ext));

  assign oReady = (state_q == IDLE) || ((state_q == DONE) && iReady);
  assign oValid = (state_q == DONE);
  assign oZ     = acc_q[2*BITS-1:0];
  assign accept = iValid && oReady;

  // The multiplier is consumed from a right-shifting register, so the
  // current group is always the low three bits plus the last bit shifted out.
  booth8_recoder u_recoder (
    .grp_i   ({q_q[2:0], qprev_q}),
    .digit_o (digit)
  );

  // Partial product: only shifts and the stored 3M feed the single adder.
  always_comb begin
    m_w = XW'($signed(m_q));
    case (digit)
      P1, N1:  mag = m_w;
      P2, N2:  mag = m_w << 1;
      P3, N3:  mag = m3_q;
      P4, N4:  mag = m_w << 2;
      default: mag = '0;
    endcase
    sel   = (digit inside {N1, N2, N3, N4}) ? -mag : mag;
    shamt = 3 * int'(cnt_q);
    pp    = AW'($signed(sel)) << shamt;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    m3_d    = m3_q;
    q_d     = q_q;
    qprev_d = qprev_q;
    acc_d   = acc_q;

    case (state_q)
      CALC: begin
        acc_d   = acc_q + pp;
        q_d     = {{3{q_q[QW-1]}}, q_q[QW-1:3]};
        qprev_d = q_q[2];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NGRP - 1)) state_d = DONE;
      end
      DONE: begin
        if (iReady) state_d = IDLE;
      end
      default: ;
    endcase

    // Capture overrides the DONE->IDLE retire so back-to-back works.
    if (accept) begin
      state_d = CALC;
      cnt_d   = '0;
      m_d     = m_ext;
      m3_d    = m_cap_w + (m_cap_w << 1);
      q_d     = QW'($signed(q_ext));
      qprev_d = 1'b0;
      acc_d   = '0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      m3_q    <= '0;
      q_q     <= '0;
      qprev_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      m3_q    <= m3_d;
      q_q     <= q_d;
      qprev_q <= qprev_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_mult_booth8_seq.sv
// Directed and random checks for mult_booth8_seq at BITS=16.
// Signed vectors are exercised only when MULT_SIGNED_EN is defined.
module tb_mult_booth8_seq;

  localparam int unsigned NGRP = 6;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iValid;
  logic        oReady;
  logic [15:0] iM, iQ;
`ifdef MULT_SIGNED_EN
  logic        iSigned;
`endif
  logic        oValid;
  logic        iReady;
  logic [31:0] oZ;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 iClk = ~iClk;

  mult_booth8_seq #(.BITS(16)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iValid  (iValid),
    .oReady  (oReady),
    .iM      (iM),
    .iQ      (iQ),
`ifdef MULT_SIGNED_EN
    .iSigned (iSigned),
`endif
    .oValid  (oValid),
    .iReady  (iReady),
    .oZ      (oZ)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] m, input logic [15:0] q, input bit s);
    logic [31:0] a, b;
    a = s ? {{16{m[15]}}, m} : {16'h0000, m};
    b = s ? {{16{q[15]}}, q} : {16'h0000, q};
    return a * b;
  endfunction

  // Called #1 after an edge with the DUT in IDLE; returns #1 after the accepting edge.
  task automatic drive_op(input logic [15:0] m, input logic [15:0] q, input bit s);
    iM = m;
    iQ = q;
`ifdef MULT_SIGNED_EN
    iSigned = s;
`else
    if (s) $display("note: signed operand request ignored in unsigned build");
`endif
    iValid = 1'b1;
    @(posedge iClk); #1;
    iValid = 1'b0;
  endtask

  task automatic wait_valid(output int unsigned lat);
    lat = 0;
    while (!oValid && lat < 20) begin
      @(posedge iClk); #1;
      lat++;
    end
  endtask

  task automatic retire(input string tag);
    iReady = 1'b1;
    @(posedge iClk); #1;
    iReady = 1'b0;
    chk({tag, "_retire_valid"}, 64'(oValid), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] m, input logic [15:0] q,
                        input bit s, input logic [31:0] exp, input int unsigned stall);
    int unsigned lat;
    drive_op(m, q, s);
    wait_valid(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(NGRP));
    chk({tag, "_z"}, 64'(oZ), 64'(exp));
    for (int unsigned i = 0; i < stall; i++) begin
      @(posedge iClk); #1;
      chk({tag, "_hold_z"}, 64'({oValid, oZ}), 64'({1'b1, exp}));
    end
    retire(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned lat;
    logic [15:0] rm, rq;
    bit          rs;

    iRst = 1'b1; iValid = 1'b0; iReady = 1'b0; iM = '0; iQ = '0;
`ifdef MULT_SIGNED_EN
    iSigned = 1'b0;
`endif
    repeat (2) @(posedge iClk);
    #1 iRst = 1'b0;
    chk("rst_ready", 64'(oReady), 64'd1);
    chk("rst_valid", 64'(oValid), 64'd0);
    chk("rst_z",     64'(oZ),     64'd0);

    // Largest unsigned operands, exact latency.
    run_op("ffff_sq", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 2);

`ifdef MULT_SIGNED_EN
    run_op("s_min_sq", 16'h8000, 16'h8000, 1'b1, 32'h40000000, 0);
    run_op("s_m1x3",   16'hFFFF, 16'h0003, 1'b1, 32'hFFFFFFFD, 0);
    run_op("u_ffffx3", 16'hFFFF, 16'h0003, 1'b0, 32'h0002FFFD, 0);
`endif

    // Zero product, then 10 cycles of backpressure.
    drive_op(16'h1234, 16'h0000, 1'b0);
    wait_valid(lat);
    chk("zero_lat", 64'(lat), 64'(NGRP));
    chk("zero_z",   64'(oZ),  64'd0);
    for (int unsigned i = 0; i < 10; i++) begin
      @(posedge iClk); #1;
      chk("bp_state", 64'({oValid, oReady, oZ}), 64'({1'b1, 1'b0, 32'h0}));
    end

    // Back-to-back: retire and capture on the same edge.
    iM = 16'h0007; iQ = 16'h0009; iValid = 1'b1; iReady = 1'b1;
`ifdef MULT_SIGNED_EN
    iSigned = 1'b0;
`endif
    @(posedge iClk); #1;
    iValid = 1'b0; iReady = 1'b0;
    chk("b2b_busy", 64'({oValid, oReady}), 64'd0);
    wait_valid(lat);
    chk("b2b_lat", 64'(lat), 64'(NGRP));
    chk("b2b_z",   64'(oZ),  64'h3F);
    retire("b2b");

    // Operand ports ignored while busy.
    drive_op(16'h0003, 16'h0005, 1'b0);
    iM = 16'hFFFF; iQ = 16'hFFFF; iValid = 1'b1;
    repeat (3) @(posedge iClk);
    #1 iValid = 1'b0;
    wait_valid(lat);
    chk("ign_lat", 64'(lat), 64'(NGRP - 3));
    chk("ign_z",   64'(oZ),  64'd15);
    retire("ign");

    // Reset during the third CALC cycle discards the in-flight result.
    drive_op(16'hABCD, 16'h1111, 1'b0);
    repeat (2) @(posedge iClk);
    #1 iRst = 1'b1;
    @(posedge iClk); #1;
    iRst = 1'b0;
    chk("midrst_state", 64'({oValid, oReady, oZ}), 64'({1'b0, 1'b1, 32'h0}));
    run_op("post_rst", 16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF, 0);

    // Random operands, signedness and backpressure.
    for (int unsigned n = 0; n < 1000; n++) begin
      rm = 16'($urandom);
      rq = 16'($urandom);
`ifdef MULT_SIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (n % 50 == 0) rm = 16'h8000;
      if (n % 70 == 0) rq = 16'hFFFF;
      run_op("rand", rm, rq, rs, ref_mul(rm, rq, rs), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
